// File: rtl/dff_bist_ctrl.sv
// dff_bist_ctrl: self-test sequencer for a small bank of D flip-flops.
// It drives zeros, ones and then an LFSR stream onto the bank's D inputs.
// Each captured Q is checked against the driven vector, and Qb against ~Q.
// Results are a Pass flag, a saturating error count and a sticky per-bit fail mask.
module dff_bist_ctrl #(
  parameter int                N_FF   = 4,
  parameter int                N_VECT = 64,
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] POLY   = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED   = 8'hA5,
  parameter int                ERR_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  output logic [N_FF-1:0]   Ff_D,
  input  logic [N_FF-1:0]   Ff_Q,
  input  logic [N_FF-1:0]   Ff_Qb,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  Err_Cnt,
  output logic [N_FF-1:0]   Fail_Mask
);

  // Vector index only has to reach N_VECT-1.
  localparam int VW = (N_VECT > 2) ? $clog2(N_VECT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [VW-1:0]    LAST_IDX = VW'(N_VECT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // One Galois right-shift step of the vector generator.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : {LFSR_W{1'b0}});
  endfunction

  // Failing bit positions: Q differs from the captured vector, or Qb is not ~Q.
  function automatic logic [N_FF-1:0] check_mask(input logic [N_FF-1:0] q,
                                                 input logic [N_FF-1:0] qb,
                                                 input logic [N_FF-1:0] e);
    return (q ^ e) | ~(q ^ qb);
  endfunction

  logic [1:0]        state_q,     state_d;
  logic [VW-1:0]     vidx_q,      vidx_d;
  logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
  logic [N_FF-1:0]   ff_d_q,      ff_d_d;
  logic              drv_vld_q,   drv_vld_d;
  logic [N_FF-1:0]   exp_q,       exp_d;
  logic              exp_vld_q,   exp_vld_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              pass_q,      pass_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;
  logic [N_FF-1:0]   fail_mask_q, fail_mask_d;
  logic              start_run_s;
  logic [N_FF-1:0]   m_s;

  // Sequencer, vector generator, check pipeline and result accumulation.
  always_comb begin
    state_d     = state_q;
    vidx_d      = vidx_q;
    lfsr_d      = lfsr_q;
    ff_d_d      = ff_d_q;
    drv_vld_d   = drv_vld_q;
    start_run_s = 1'b0;
    m_s         = {N_FF{1'b0}};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          // V_0 (all zeros) goes out on the accepting edge itself.
          start_run_s = 1'b1;
          state_d     = S_RUN;
          vidx_d      = {VW{1'b0}};
          ff_d_d      = {N_FF{1'b0}};
          drv_vld_d   = 1'b1;
          lfsr_d      = SEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (vidx_q == LAST_IDX) begin
          state_d   = S_DRAIN;
          ff_d_d    = {N_FF{1'b0}};
          drv_vld_d = 1'b0;
        end else begin
          vidx_d = vidx_q + VW'(1);
          if (vidx_q == {VW{1'b0}}) begin
            ff_d_d = {N_FF{1'b1}};
          end else begin
            ff_d_d = lfsr_q[N_FF-1:0];
            lfsr_d = lfsr_step(lfsr_q);
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The flop captures Ff_D one edge later; compare on the edge after that.
    exp_d     = ff_d_q;
    exp_vld_d = drv_vld_q;
    if (exp_vld_q) begin
      m_s = check_mask(Ff_Q, Ff_Qb, exp_q);
    end else begin
      m_s = {N_FF{1'b0}};
    end

    if (start_run_s) begin
      err_cnt_d   = {ERR_W{1'b0}};
      fail_mask_d = {N_FF{1'b0}};
      pass_d      = 1'b0;
    end else begin
      if ((m_s != {N_FF{1'b0}}) && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      fail_mask_d = fail_mask_q | m_s;
      // Verdict includes the final check performed on the DRAIN exit edge.
      if (state_q == S_DRAIN) begin
        pass_d = (err_cnt_d == {ERR_W{1'b0}});
      end else begin
        pass_d = pass_q;
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      vidx_q      <= {VW{1'b0}};
      lfsr_q      <= SEED;
      ff_d_q      <= {N_FF{1'b0}};
      drv_vld_q   <= 1'b0;
      exp_q       <= {N_FF{1'b0}};
      exp_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
      fail_mask_q <= {N_FF{1'b0}};
    end else begin
      state_q     <= state_d;
      vidx_q      <= vidx_d;
      lfsr_q      <= lfsr_d;
      ff_d_q      <= ff_d_d;
      drv_vld_q   <= drv_vld_d;
      exp_q       <= exp_d;
      exp_vld_q   <= exp_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign Ff_D      = ff_d_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign Err_Cnt   = err_cnt_q;
  assign Fail_Mask = fail_mask_q;

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// tb_dff_bist_ctrl: drives the BIST controller against a behavioural flop bank
// with injectable faults and compares against a per-vector reference model.
module tb_dff_bist_ctrl;

  localparam int         N_FF   = 4;
  localparam int         N_VECT = 64;
  localparam logic [7:0] POLY   = 8'hB8;
  localparam logic [7:0] SEED   = 8'hA5;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [3:0] Ff_D, Ff_Q, Ff_Qb;
  logic       Busy, Done, Pass;
  logic [7:0] Err_Cnt;
  logic [3:0] Fail_Mask;

  logic       Start4;
  logic [3:0] Ff_D4, Ff_Q4, Ff_Qb4;
  logic       Busy4, Done4, Pass4;
  logic [3:0] Err_Cnt4;
  logic [3:0] Fail_Mask4;

  // fault controls: stuck mask/value, Q inversion, Qb tied to Q
  logic [3:0] f_sm, f_sv, f_inv, f_tie;
  logic [3:0] bank_q, bank4_q, q_eff;

  logic [3:0] vec [N_VECT];
  int n_checks = 0;
  int n_pass   = 0;

  dff_bist_ctrl u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Ff_D(Ff_D), .Ff_Q(Ff_Q), .Ff_Qb(Ff_Qb),
    .Busy(Busy), .Done(Done), .Pass(Pass), .Err_Cnt(Err_Cnt), .Fail_Mask(Fail_Mask)
  );

  dff_bist_ctrl #(.ERR_W(4)) u_dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start4), .Ff_D(Ff_D4), .Ff_Q(Ff_Q4), .Ff_Qb(Ff_Qb4),
    .Busy(Busy4), .Done(Done4), .Pass(Pass4), .Err_Cnt(Err_Cnt4), .Fail_Mask(Fail_Mask4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // flop banks under test
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bank_q  <= 4'h0;
      bank4_q <= 4'h0;
    end else begin
      bank_q  <= Ff_D;
      bank4_q <= Ff_D4;
    end
  end

  assign q_eff  = ((bank_q & ~f_sm) | (f_sv & f_sm)) ^ f_inv;
  assign Ff_Q   = q_eff;
  assign Ff_Qb  = (~q_eff & ~f_tie) | (q_eff & f_tie);
  assign Ff_Q4  = ~bank4_q;
  assign Ff_Qb4 = bank4_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    else
      n_pass++;
  endtask

  // expected run result from the vector list, one vector at a time
  task automatic model(input logic [3:0] sm, input logic [3:0] sv, input logic [3:0] inv,
                       input logic [3:0] tie, input int lim,
                       output int cnt, output logic [3:0] mask);
    logic [3:0] q, qb, m;
    cnt  = 0;
    mask = 4'h0;
    for (int i = 0; i < N_VECT; i++) begin
      q  = ((vec[i] & ~sm) | (sv & sm)) ^ inv;
      qb = (~q & ~tie) | (q & tie);
      m  = (q ^ vec[i]) | ~(q ^ qb);
      if (m != 4'h0 && cnt < lim) cnt++;
      mask = mask | m;
    end
  endtask

  task automatic do_run(input string name, input bit repulse);
    int cnt, busy_cnt, done_cnt, done_cyc, prof_err, vec_err;
    logic [3:0] mask, got_mask;
    logic [7:0] got_cnt;
    logic got_pass;
    model(f_sm, f_sv, f_inv, f_tie, 255, cnt, mask);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; prof_err = 0; vec_err = 0;
    got_pass = 1'b0; got_cnt = 8'h0; got_mask = 4'h0;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    for (int k = 0; k < N_VECT + 4; k++) begin
      if (Busy) busy_cnt++;
      if (Busy !== (k <= N_VECT)) prof_err++;
      if (k < N_VECT && Ff_D !== vec[k]) vec_err++;
      if (k == N_VECT && Ff_D !== 4'h0) vec_err++;
      if (Done) begin
        done_cnt++; done_cyc = k;
        got_pass = Pass; got_cnt = Err_Cnt; got_mask = Fail_Mask;
      end
      if (repulse && k == 10) Start = 1'b1;
      if (k == 11) Start = 1'b0;
      @(negedge Clk);
    end
    chk({name, ".busy_profile"}, prof_err, 0);
    chk({name, ".busy_cycles"}, busy_cnt, N_VECT + 1);
    chk({name, ".done_cycle"}, done_cyc, N_VECT + 1);
    chk({name, ".done_pulses"}, done_cnt, 1);
    chk({name, ".vec_stream"}, vec_err, 0);
    chk({name, ".err_cnt"}, got_cnt, cnt);
    chk({name, ".fail_mask"}, got_mask, mask);
    chk({name, ".pass"}, got_pass, (cnt == 0));
    chk({name, ".pass_held"}, Pass, (cnt == 0));
  endtask

  initial begin : main
    logic [7:0] l;
    int cnt, done_cnt, busy_cnt, d1, d2;
    logic [3:0] mask;
    bit seen;

    vec[0] = 4'h0;
    vec[1] = 4'hF;
    l = SEED;
    for (int i = 2; i < N_VECT; i++) begin
      vec[i] = l[3:0];
      l = (l >> 1) ^ (l[0] ? POLY : 8'h00);
    end

    Rst_n = 1'b0; Start = 1'b0; Start4 = 1'b0;
    f_sm = 4'h0; f_sv = 4'h0; f_inv = 4'h0; f_tie = 4'h0;
    repeat (2) @(negedge Clk);
    chk("rst.ff_d", Ff_D, 0);
    chk("rst.busy", Busy, 0);
    chk("rst.done", Done, 0);
    chk("rst.pass", Pass, 0);
    chk("rst.err_cnt", Err_Cnt, 0);
    chk("rst.fail_mask", Fail_Mask, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    do_run("ideal", 1'b0);
    f_sm = 4'b0100; f_sv = 4'b0000;
    do_run("q2_sa0", 1'b0);
    f_sm = 4'h0; f_tie = 4'b0001;
    do_run("qb0_tie", 1'b0);
    f_tie = 4'h0;
    do_run("repulse", 1'b1);

    // Start held high: back-to-back runs
    d1 = -1; d2 = -1;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 136; k++) begin
      if (Done) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 131) Start = 1'b0;
      @(negedge Clk);
    end
    chk("hold.done1", d1, N_VECT + 1);
    chk("hold.done2", d2, 2 * N_VECT + 3);
    chk("hold.pass", Pass, 1);
    chk("hold.idle", Busy, 0);

    // randomized faults and start gaps
    for (int r = 0; r < 6; r++) begin
      f_sm = 4'h0; f_sv = 4'h0; f_inv = 4'h0; f_tie = 4'h0;
      case ($urandom_range(0, 3))
        0: ;
        1: begin f_sm = 4'($urandom); f_sv = 4'($urandom); end
        2: f_tie = 4'($urandom);
        default: begin f_inv = 4'($urandom); f_tie = 4'($urandom) & 4'($urandom); end
      endcase
      repeat ($urandom_range(0, 4)) @(negedge Clk);
      do_run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a run
    f_sm = 4'b0100; f_sv = 4'h0; f_inv = 4'h0; f_tie = 4'h0;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (30) @(negedge Clk);
    chk("midrst.err_before", (Err_Cnt != 8'h0), 1);
    chk("midrst.busy_before", Busy, 1);
    Rst_n = 1'b0;
    #1;
    chk("midrst.ff_d", Ff_D, 0);
    chk("midrst.busy", Busy, 0);
    chk("midrst.err_cnt", Err_Cnt, 0);
    chk("midrst.fail_mask", Fail_Mask, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    repeat (150) begin
      @(negedge Clk);
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
    end
    chk("midrst.no_done", done_cnt, 0);
    chk("midrst.no_busy", busy_cnt, 0);

    // narrow counter saturation, all Q inverted
    model(4'h0, 4'h0, 4'hF, 4'h0, 15, cnt, mask);
    @(negedge Clk); Start4 = 1'b1;
    @(negedge Clk); Start4 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (Done4) seen = 1'b1;
      else @(negedge Clk);
    end
    chk("sat.done_seen", seen, 1);
    chk("sat.err_cnt", Err_Cnt4, cnt);
    chk("sat.fail_mask", Fail_Mask4, mask);
    chk("sat.pass", Pass4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
